// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset datapath: fetch, decode, execute,
// memory access and write-back over a shared single-port memory, plus a retired-instruction counter.
module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   iord,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   illegal,
  output logic                   halted,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } moore_t;

  state_e                 state_q, state_d;
  logic [5:0]             opc_q, opc_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  moore_t                 moore_q, moore_d;
  logic                   retire;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: is_supported = 1'b1;
      default:                                          is_supported = 1'b0;
    endcase
  endfunction

  // Moore outputs for a given state; evaluated on the next state so they can be registered.
  function automatic moore_t moore_decode(input state_e st, input logic [5:0] op);
    moore_t m;
    m = '0;
    case (st)
      S_FETCH: begin
        m.mem_req   = 1'b1;
        m.alu_src_b = 2'b01;
      end
      S_DECODE: m.alu_src_b = 2'b11;
      S_EXEC: begin
        m.alu_src_a = 1'b1;
        case (op)
          OP_RTYPE: m.alu_op = 2'b10;
          OP_BEQ: begin
            m.alu_op = 2'b01;
            m.pc_src = 1'b1;
          end
          default: m.alu_src_b = 2'b10;
        endcase
      end
      S_MEM: begin
        m.mem_req = 1'b1;
        m.iord    = 1'b1;
        m.mem_we  = (op == OP_SW);
      end
      S_WB: begin
        m.reg_write  = 1'b1;
        m.reg_dst    = (op == OP_RTYPE);
        m.mem_to_reg = (op == OP_LW);
      end
      S_HALT:  m.halted = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    retired_d = retired_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        opc_d = opcode;
        if (opcode == OP_HALT)      state_d = S_HALT;
        else if (!is_supported(opcode)) state_d = S_FETCH;
        else                        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opc_q)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ:            retire  = 1'b1;
          default:           state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (opc_q == OP_LW) state_d = S_WB;
          else                retire  = 1'b1;
        end
      end
      S_WB:    retire  = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // run is only honoured here and in IDLE, so mid-instruction changes wait for retirement.
    if (retire) begin
      retired_d = retired_q + COUNT_ONE;
      state_d   = run ? S_FETCH : S_IDLE;
    end
    moore_d = moore_decode(state_d, opc_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      opc_q     <= 6'h00;
      retired_q <= '0;
      moore_q   <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      retired_q <= retired_d;
      moore_q   <= moore_d;
    end
  end

  // Handshake-dependent strobes stay combinational so they land in the ack/zero cycle itself.
  assign ir_write = (state_q == S_FETCH) && mem_ack;
  assign pc_write = ((state_q == S_FETCH) && mem_ack) ||
                    ((state_q == S_EXEC) && (opc_q == OP_BEQ) && zero);
  assign illegal  = (state_q == S_DECODE) && !is_supported(opcode);

  assign mem_req    = moore_q.mem_req;
  assign mem_we     = moore_q.mem_we;
  assign iord       = moore_q.iord;
  assign pc_src     = moore_q.pc_src;
  assign reg_write  = moore_q.reg_write;
  assign reg_dst    = moore_q.reg_dst;
  assign mem_to_reg = moore_q.mem_to_reg;
  assign alu_src_a  = moore_q.alu_src_a;
  assign alu_src_b  = moore_q.alu_src_b;
  assign alu_op     = moore_q.alu_op;
  assign halted     = moore_q.halted;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance with a 2-bit counter checks wrap-around.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;

  logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic illegal, halted;
  logic [2:0] state;
  logic [15:0] retired;

  logic w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_src, w_reg_write, w_reg_dst;
  logic w_mem_to_reg, w_alu_src_a, w_illegal, w_halted;
  logic [1:0] w_alu_src_b, w_alu_op, w_retired;
  logic [2:0] w_state;

  always #5 clock = ~clock;

  multicycle_control #(.COUNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .halted(halted), .state(state), .retired(retired)
  );

  multicycle_control #(.COUNT_WIDTH(2)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .iord(w_iord), .ir_write(w_ir_write), .pc_write(w_pc_write),
    .pc_src(w_pc_src), .reg_write(w_reg_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .illegal(w_illegal),
    .halted(w_halted), .state(w_state), .retired(w_retired)
  );

  localparam logic [5:0] JUNK = 6'h3E;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] ctrl;
    logic [15:0] ret;
    logic [1:0]  ret2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_retired = 16'd0;
  logic        run_v = 1'b0;
  logic        reset_v = 1'b0;

  function automatic logic supported(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h08) || (op == 6'h23) ||
           (op == 6'h2B) || (op == 6'h04) || (op == 6'h3F);
  endfunction

  // Expected control word from the per-state output table:
  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], illegal, halted}
  function automatic logic [15:0] exp_ctrl(input logic [2:0] st, input logic [5:0] op,
                                           input logic ack, input logic z);
    logic rq, we, io, irw, pcw, pcs, rw, rd, m2r, sa, ill, hlt;
    logic [1:0] sb2, aop;
    {rq, we, io, irw, pcw, pcs, rw, rd, m2r, sa, ill, hlt} = '0;
    sb2 = 2'b00;
    aop = 2'b00;
    case (st)
      3'd1: begin rq = 1; sb2 = 2'b01; irw = ack; pcw = ack; end
      3'd2: begin sb2 = 2'b11; ill = !supported(op); end
      3'd3: begin
        sa = 1;
        if (op == 6'h00)      aop = 2'b10;
        else if (op == 6'h04) begin aop = 2'b01; pcs = 1; pcw = z; end
        else                  sb2 = 2'b10;
      end
      3'd4: begin rq = 1; io = 1; we = (op == 6'h2B); end
      3'd5: begin rw = 1; rd = (op == 6'h00); m2r = (op == 6'h23); end
      3'd6: hlt = 1;
      default: ;
    endcase
    return {rq, we, io, irw, pcw, pcs, rw, rd, m2r, sa, sb2, aop, ill, hlt};
  endfunction

  task automatic applyStep(input string tag, input logic [2:0] st, input logic [5:0] op_in,
                           input logic ack, input logic z, input logic [5:0] iop);
    exp_t e;
    logic [15:0] obs;
    @(negedge clock);
    reset_n = reset_v;
    run     = run_v;
    opcode  = op_in;
    mem_ack = ack;
    zero    = z;
    e.tag  = tag;
    e.st   = reset_v ? st : 3'd0;
    e.ctrl = reset_v ? exp_ctrl(st, iop, ack, z) : 16'h0000;
    e.ret  = exp_retired;
    e.ret2 = exp_retired[1:0];
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, illegal, halted};
    checks++;
    assert (state === e.st) else begin
      failures++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
    end
    checks++;
    assert (obs === e.ctrl) else begin
      failures++;
      $error("FAIL %s ctrl: got %b expected %b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (retired === e.ret) else begin
      failures++;
      $error("FAIL %s retired: got %0d expected %0d", e.tag, retired, e.ret);
    end
    checks++;
    assert (w_retired === e.ret2) else begin
      failures++;
      $error("FAIL %s retired_wrap: got %0d expected %0d", e.tag, w_retired, e.ret2);
    end
  endtask

  // One instruction from FETCH to retirement; JUNK on opcode outside DECODE exercises the latch.
  task automatic applyInstr(input string name, input logic [5:0] op, input int fetch_wait,
                            input int mem_wait, input logic z, input bit drop_run);
    for (int i = 0; i < fetch_wait; i++) applyStep({name, " fetch wait"}, 3'd1, JUNK, 1'b0, 1'b1, op);
    applyStep({name, " fetch"}, 3'd1, JUNK, 1'b1, 1'b1, op);
    applyStep({name, " decode"}, 3'd2, op, 1'b0, 1'b1, op);
    if (op == 6'h3F || !supported(op)) return;
    if (drop_run) run_v = 1'b0;
    applyStep({name, " exec"}, 3'd3, JUNK, 1'b0, z, op);
    if (op == 6'h04) begin
      exp_retired++;
      return;
    end
    if (op == 6'h23 || op == 6'h2B) begin
      for (int i = 0; i < mem_wait; i++) applyStep({name, " mem wait"}, 3'd4, JUNK, 1'b0, 1'b1, op);
      applyStep({name, " mem ack"}, 3'd4, JUNK, 1'b1, 1'b1, op);
      if (op == 6'h2B) begin
        exp_retired++;
        return;
      end
    end
    applyStep({name, " wb"}, 3'd5, JUNK, 1'b0, 1'b1, op);
    exp_retired++;
  endtask

  initial begin
    reset_v = 1'b0;
    run_v   = 1'b0;
    applyStep("reset held", 3'd0, JUNK, 1'b1, 1'b1, 6'h00);
    applyStep("reset held 2", 3'd0, JUNK, 1'b0, 1'b0, 6'h00);
    reset_v = 1'b1;
    run_v   = 1'b1;
    applyStep("release idle", 3'd0, JUNK, 1'b0, 1'b0, 6'h00);

    applyInstr("rtype", 6'h00, 0, 0, 1'b0, 1'b0);
    applyInstr("lw", 6'h23, 0, 1, 1'b0, 1'b0);
    applyInstr("sw", 6'h2B, 1, 0, 1'b0, 1'b0);
    applyInstr("beq z1", 6'h04, 0, 0, 1'b1, 1'b0);
    applyInstr("beq z0", 6'h04, 0, 0, 1'b0, 1'b0);
    applyInstr("addi drop run", 6'h08, 0, 0, 1'b0, 1'b1);

    applyStep("idle after drop", 3'd0, JUNK, 1'b1, 1'b1, 6'h00);
    applyStep("idle hold", 3'd0, JUNK, 1'b0, 1'b0, 6'h00);
    run_v = 1'b1;
    applyStep("idle run", 3'd0, JUNK, 1'b0, 1'b0, 6'h00);

    applyInstr("illegal", 6'h3E, 0, 0, 1'b0, 1'b0);

    applyStep("lw2 fetch", 3'd1, JUNK, 1'b1, 1'b1, 6'h23);
    applyStep("lw2 decode", 3'd2, 6'h23, 1'b0, 1'b1, 6'h23);
    applyStep("lw2 exec", 3'd3, JUNK, 1'b0, 1'b0, 6'h23);
    applyStep("lw2 mem wait", 3'd4, JUNK, 1'b0, 1'b1, 6'h23);
    reset_v     = 1'b0;
    exp_retired = 16'd0;
    applyStep("reset mid mem", 3'd0, JUNK, 1'b0, 1'b1, 6'h23);
    applyStep("reset mid mem 2", 3'd0, JUNK, 1'b1, 1'b1, 6'h23);
    reset_v = 1'b1;
    run_v   = 1'b1;
    applyStep("idle after mid reset", 3'd0, JUNK, 1'b0, 1'b0, 6'h00);

    applyInstr("halt", 6'h3F, 0, 0, 1'b0, 1'b0);
    applyStep("halted 1", 3'd6, JUNK, 1'b0, 1'b1, 6'h3F);
    run_v = 1'b0;
    applyStep("halted 2", 3'd6, JUNK, 1'b1, 1'b1, 6'h3F);
    run_v = 1'b1;
    applyStep("halted 3", 3'd6, 6'h00, 1'b1, 1'b0, 6'h3F);
    applyStep("halted 4", 3'd6, JUNK, 1'b0, 1'b0, 6'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
